// File: rtl/rle_double_fifo_pkg.sv
// -----------------------------------------------------------------------------
// rle_double_fifo_pkg
// Shared constants and types for the RLE ping-pong buffer.
//   DATA_W  : width of one RLE word
//   DEPTH   : entries per buffer (one 8x8 block)
//   ADDR_W  : pointer width, log2(DEPTH)
//   entry_t : one buffered RLE word
// -----------------------------------------------------------------------------
package rle_double_fifo_pkg;

    localparam int DATA_W = 20;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] entry_t;

endpackage

// File: rtl/rle_fifo.sv
// -----------------------------------------------------------------------------
// rle_fifo
// Single-clock FIFO with a registered read port. A pop loads dout on the
// clock edge; dout holds until the next successful pop.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   wr_en, din     : write request and data (dropped when full)
//   rd_en          : pop request (ignored when empty)
//   dout           : most recently popped word
//   empty, full    : occupancy flags from the entry count
// -----------------------------------------------------------------------------
module rle_fifo #(
    parameter int DATA_W = rle_double_fifo_pkg::DATA_W,
    parameter int DEPTH  = rle_double_fifo_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    import rle_double_fifo_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              wr_ok;
    logic              rd_ok;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Explicit wrap keeps the FIFO correct for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rle_double_fifo.sv
// -----------------------------------------------------------------------------
// rle_double_fifo
// Ping-pong pair of FIFOs for RLE words. buf_sel picks the write side
// (0 = A, 1 = B); the other buffer is the read side. Roles swap freely and
// each buffer keeps its contents and pointers across a swap.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   data_in     : RLE word to write (opaque)
//   wren        : write into the write-side buffer
//   buf_sel     : write-side select
//   rd_req      : pop from the read-side buffer
//   fifo_empty  : read-side buffer holds no entries (combinational)
//   data_out    : most recently popped word
// -----------------------------------------------------------------------------
module rle_double_fifo #(
    parameter int DATA_W = rle_double_fifo_pkg::DATA_W,
    parameter int DEPTH  = rle_double_fifo_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wren,
    input  logic              buf_sel,
    input  logic              rd_req,
    output logic              fifo_empty,
    output logic [DATA_W-1:0] data_out
);
    import rle_double_fifo_pkg::*;

    logic              wr_a, wr_b, rd_a, rd_b;
    logic              empty_a, empty_b, full_a, full_b;
    logic [DATA_W-1:0] dout_a, dout_b;
    logic              last_pop_b;
    logic              unused_full;

    assign wr_a = wren   && !buf_sel;
    assign wr_b = wren   &&  buf_sel;
    assign rd_a = rd_req &&  buf_sel;
    assign rd_b = rd_req && !buf_sel;

    assign fifo_empty  = buf_sel ? empty_a : empty_b;
    assign unused_full = full_a | full_b;

    rle_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_a),
        .rd_en (rd_a),
        .din   (data_in),
        .dout  (dout_a),
        .empty (empty_a),
        .full  (full_a)
    );

    rle_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_b),
        .rd_en (rd_b),
        .din   (data_in),
        .dout  (dout_b),
        .empty (empty_b),
        .full  (full_b)
    );

    // Track which buffer delivered the last pop so data_out holds across a
    // buf_sel swap instead of flipping to the other buffer's stale word.
    always_ff @(posedge clk) begin
        if (reset)                       last_pop_b <= 1'b0;
        else if (rd_req && !fifo_empty)  last_pop_b <= !buf_sel;
    end

    assign data_out = last_pop_b ? dout_b : dout_a;

endmodule

// File: tb/tb_rle_double_fifo.sv
module tb_rle_double_fifo;
    import rle_double_fifo_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    entry_t data_in;
    logic   wren, buf_sel, rd_req;
    logic   fifo_empty;
    entry_t data_out;

    int n_cmp = 0;
    int n_bad = 0;

    entry_t exp_q[$];
    logic   pop_issued = 1'b0;
    logic   pop_seen   = 1'b0;

    always #5 clk = ~clk;

    rle_double_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .wren       (wren),
        .buf_sel    (buf_sel),
        .rd_req     (rd_req),
        .fifo_empty (fifo_empty),
        .data_out   (data_out)
    );

    // Monitor: a read request at edge N is checked at the following negedge.
    always @(posedge clk) pop_seen = pop_issued;

    always @(negedge clk) begin
        if (pop_seen) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: data_out=%h with no expected entry", data_out);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_bad++;
                    $display("FAIL data_out: got %h expected %h", data_out, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; with chk=1 the word expected on data_out
    // after this edge is queued for the monitor.
    task automatic step(input logic sel, input logic wr, input entry_t d,
                        input logic rd, input logic ck, input entry_t e);
        buf_sel    = sel;
        wren       = wr;
        data_in    = d;
        rd_req     = rd;
        pop_issued = ck;
        if (ck) exp_q.push_back(e);
        @(posedge clk);
        #1;
        wren       = 1'b0;
        rd_req     = 1'b0;
        pop_issued = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; data_in = '0; wren = 1'b0; buf_sel = 1'b0; rd_req = 1'b0;
        @(posedge clk); #1;
        // Inputs asserted during reset must be ignored.
        wren = 1'b1; rd_req = 1'b1; data_in = 20'h12345;
        @(posedge clk); #1;
        reset = 1'b0; wren = 1'b0; rd_req = 1'b0;

        // Reset state
        buf_sel = 1'b0; #1;
        chk("rst_empty_sel0", 32'(fifo_empty), 32'd1);
        chk("rst_dout", 32'(data_out), 32'd0);
        buf_sel = 1'b1; #1;
        chk("rst_empty_sel1", 32'(fifo_empty), 32'd1);

        // Fill A with four words, then read them back
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, entry_t'(i), 1'b0, 1'b0, '0);
        buf_sel = 1'b1; #1;
        chk("a4_not_empty", 32'(fifo_empty), 32'd0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, entry_t'(i));
        chk("a4_drained_empty", 32'(fifo_empty), 32'd1);

        // Ping-pong: fill A, then write B while draining A
        step(1'b0, 1'b1, 20'h00010, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 20'h00011, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 20'h00012, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 20'hABCDE, 1'b1, 1'b1, 20'h00010);
        step(1'b1, 1'b0, '0,        1'b1, 1'b1, 20'h00011);
        step(1'b1, 1'b0, '0,        1'b1, 1'b1, 20'h00012);
        chk("pp_a_empty", 32'(fifo_empty), 32'd1);
        buf_sel = 1'b0; #1;
        chk("pp_b_not_empty", 32'(fifo_empty), 32'd0);
        chk("pp_dout_holds_on_swap", 32'(data_out), 32'h00012);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 20'hABCDE);
        chk("pp_b_empty", 32'(fifo_empty), 32'd1);

        // Overflow and wrap: A's pointers start at 7 here, so 64 entries wrap
        for (int i = 0; i < 65; i++) step(1'b0, 1'b1, entry_t'(20'h00100 + i), 1'b0, 1'b0, '0);
        buf_sel = 1'b1; #1;
        chk("full_not_empty", 32'(fifo_empty), 32'd0);
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, entry_t'(20'h00100 + i));
        chk("full_drained_empty", 32'(fifo_empty), 32'd1);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 20'h0013F);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, 20'h0013F);

        // Reset mid-operation discards A's contents
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, entry_t'(20'h00200 + i), 1'b0, 1'b0, '0);
        do_reset();
        buf_sel = 1'b1; #1;
        chk("midrst_empty_sel1", 32'(fifo_empty), 32'd1);
        chk("midrst_dout", 32'(data_out), 32'd0);
        buf_sel = 1'b0; #1;
        chk("midrst_empty_sel0", 32'(fifo_empty), 32'd1);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 20'h00000);

        // Drain the scoreboard with a bounded wait
        begin
            int budget = 20;
            while (exp_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_timeout: %0d entries left expected 0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
